fun_fpusqr_sched: RTL and testbench

Issue-side sequencer for the shared iterative sqrt/divide unit (the `fun_fpusqr` low/high pair). It accepts sqrt/div micro-ops from the issue port, starts the unit, and counts the op's fixed latency. It back-pressures issue via `fxFRT_pause` while the unit is occupied, then claims the alternate write-back slot via `fxFRT_alten`, yielding to regular results. A one-entry pending slot absorbs the op that arrives in the cycle pause rises.

---
 rtl/fpusqr_pkg.sv | 38 +++
 rtl/fun_fpusqr_sched_if.sv | 34 +++
 rtl/fpusqr_lat_cnt.sv | 35 +++
 rtl/fun_fpusqr_sched.sv | 168 ++++++++++++++++
 tb/tb_fun_fpusqr_sched.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/fpusqr_pkg.sv
// Shared types, opcode constants and helpers for the sqrt/divide issue sequencer.
package fpusqr_pkg;

    localparam int unsigned MASK_W = 4;
    localparam int unsigned OP_W   = 13;
    localparam int unsigned REG_W  = 9;
    localparam int unsigned II_W   = 10;
    localparam int unsigned CNT_W  = 6;

    // Sqrt/divide opcodes, same encodings as the fpoperations table
    localparam logic [OP_W-1:0] fop_sqrtS  = 13'h0C0;
    localparam logic [OP_W-1:0] fop_divS   = 13'h0C1;
    localparam logic [OP_W-1:0] fop_sqrtDL = 13'h0C4;
    localparam logic [OP_W-1:0] fop_sqrtDH = 13'h0C5;
    localparam logic [OP_W-1:0] fop_divDL  = 13'h0C6;
    localparam logic [OP_W-1:0] fop_divDH  = 13'h0C7;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        WB
    } state_e;

    typedef struct packed {
        logic [MASK_W-1:0] mask;
        logic [OP_W-1:0]   op;
        logic [REG_W-1:0]  regno;
        logic [II_W-1:0]   ii;
    } op_rec_t;

    function automatic logic is_double(input logic [OP_W-1:0] op);
        case (op)
            fop_sqrtDL, fop_sqrtDH, fop_divDL, fop_divDH: return 1'b1;
            default:                                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/fun_fpusqr_sched_if.sv
// Issue-port, write-back and unit-start signals between the pipeline and the sequencer.
interface fun_fpusqr_sched_if;
    import fpusqr_pkg::*;

    logic              except;
    logic [MASK_W-1:0] u1_en;
    logic [OP_W-1:0]   u1_op;
    logic [REG_W-1:0]  u1_regNo;
    logic [II_W-1:0]   u1_II;
    logic              wb_busy;

    logic              sq_start;
    logic [OP_W-1:0]   sq_op;
    logic [MASK_W-1:0] fxFRT_pause;
    logic [MASK_W-1:0] fxFRT_alten;
    logic [MASK_W-1:0] outEn;
    logic [II_W-1:0]   outII;
    logic [OP_W-1:0]   outOp;
    logic [REG_W-1:0]  FUreg;
    logic              FUwen;

    modport master (
        output except, u1_en, u1_op, u1_regNo, u1_II, wb_busy,
        input  sq_start, sq_op, fxFRT_pause, fxFRT_alten,
               outEn, outII, outOp, FUreg, FUwen
    );

    modport slave (
        input  except, u1_en, u1_op, u1_regNo, u1_II, wb_busy,
        output sq_start, sq_op, fxFRT_pause, fxFRT_alten,
               outEn, outII, outOp, FUreg, FUwen
    );

endinterface

// File: rtl/fpusqr_lat_cnt.sv
// Latency down-counter: load takes priority, otherwise decrements and holds at zero.
module fpusqr_lat_cnt
    import fpusqr_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/fun_fpusqr_sched.sv
// Issue-side sequencer for the shared iterative sqrt/divide unit: start, latency count,
// alternate write-back claim and a one-entry pending slot for the op racing the pause.
module fun_fpusqr_sched
    import fpusqr_pkg::*;
#(
    parameter int unsigned LAT_S = 14,
    parameter int unsigned LAT_D = 28
) (
    input  logic               clk,
    input  logic               rst,
    fun_fpusqr_sched_if.slave  io
);

    state_e            state_q, state_d;
    op_rec_t           op_q, op_d;
    op_rec_t           pend_q, pend_d;
    logic              pend_vld_q, pend_vld_d;
    logic              sq_start_q, sq_start_d;
    logic [OP_W-1:0]   sq_op_q, sq_op_d;
    logic [MASK_W-1:0] pause_q, pause_d;
    logic [MASK_W-1:0] wb_mask_q, wb_mask_d;
    logic [II_W-1:0]   outii_q, outii_d;
    logic [OP_W-1:0]   outop_q, outop_d;
    logic [REG_W-1:0]  fureg_q, fureg_d;
    logic              fuwen_q, fuwen_d;

    logic              in_vld_c;
    op_rec_t           in_rec_c;
    op_rec_t           start_rec_c;
    logic              start_slot_c;
    logic              fire_c;
    logic              pend_ovf_c;
    logic              cnt_load_c;
    logic [CNT_W-1:0]  cnt_val_c;
    logic              cnt_zero_c;

    fpusqr_lat_cnt u_lat_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load_c),
        .load_val (cnt_val_c),
        .dec      (state_q == RUN),
        .zero_c   (cnt_zero_c)
    );

    // Outputs are registered, so wb_busy is looked at one cycle ahead of the write-back slot
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        pend_d       = pend_q;
        pend_vld_d   = pend_vld_q;
        sq_start_d   = 1'b0;
        sq_op_d      = '0;
        wb_mask_d    = '0;
        outii_d      = '0;
        outop_d      = '0;
        fureg_d      = '0;
        fuwen_d      = 1'b0;
        start_slot_c = 1'b0;
        fire_c       = 1'b0;
        pend_ovf_c   = 1'b0;
        cnt_load_c   = 1'b0;
        cnt_val_c    = '0;

        in_vld_c    = (|io.u1_en) && !io.except;
        in_rec_c    = '{mask: io.u1_en, op: io.u1_op, regno: io.u1_regNo, ii: io.u1_II};
        start_rec_c = pend_vld_q ? pend_q : in_rec_c;

        if (io.except) begin
            state_d    = IDLE;
            pend_vld_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: start_slot_c = 1'b1;
                RUN: begin
                    if (cnt_zero_c) begin
                        state_d = WB;
                        fire_c  = !io.wb_busy;
                    end
                end
                WB: begin
                    if (fuwen_q) begin
                        start_slot_c = 1'b1;
                    end else begin
                        fire_c = !io.wb_busy;
                    end
                end
                default: state_d = IDLE;
            endcase

            // The cycle a write-back is visible doubles as an idle slot so back-to-back ops lose nothing
            if (start_slot_c) begin
                state_d    = IDLE;
                pend_vld_d = 1'b0;
                pend_ovf_c = pend_vld_q && in_vld_c;
                if (pend_vld_q || in_vld_c) begin
                    op_d       = start_rec_c;
                    sq_start_d = 1'b1;
                    sq_op_d    = start_rec_c.op;
                    cnt_load_c = 1'b1;
                    cnt_val_c  = is_double(start_rec_c.op) ? CNT_W'(LAT_D - 1) : CNT_W'(LAT_S - 1);
                    state_d    = RUN;
                end
            end else if (in_vld_c) begin
                if (pend_vld_q) begin
                    pend_ovf_c = 1'b1;
                end else begin
                    pend_d     = in_rec_c;
                    pend_vld_d = 1'b1;
                end
            end

            if (fire_c) begin
                fuwen_d   = 1'b1;
                wb_mask_d = op_q.mask;
                outii_d   = op_q.ii;
                outop_d   = op_q.op;
                fureg_d   = op_q.regno;
            end
        end

        pause_d = ((state_d != IDLE) || pend_vld_d) ? 4'hF : 4'h0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            sq_start_q <= 1'b0;
            sq_op_q    <= '0;
            pause_q    <= '0;
            wb_mask_q  <= '0;
            outii_q    <= '0;
            outop_q    <= '0;
            fureg_q    <= '0;
            fuwen_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            sq_start_q <= sq_start_d;
            sq_op_q    <= sq_op_d;
            pause_q    <= pause_d;
            wb_mask_q  <= wb_mask_d;
            outii_q    <= outii_d;
            outop_q    <= outop_d;
            fureg_q    <= fureg_d;
            fuwen_q    <= fuwen_d;
        end
    end

    // Issuing into a full pending slot is an issue-side protocol error; the op is dropped
    pend_ovf_a: assert property (@(posedge clk) disable iff (rst) !pend_ovf_c);

    assign io.sq_start    = sq_start_q;
    assign io.sq_op       = sq_op_q;
    assign io.fxFRT_pause = pause_q;
    assign io.fxFRT_alten = wb_mask_q;
    assign io.outEn       = wb_mask_q;
    assign io.outII       = outii_q;
    assign io.outOp       = outop_q;
    assign io.FUreg       = fureg_q;
    assign io.FUwen       = fuwen_q;

endmodule

// File: tb/tb_fun_fpusqr_sched.sv
// Directed bench for fun_fpusqr_sched: latency, pending slot, wb_busy stall, except and reset.
module tb_fun_fpusqr_sched;
    import fpusqr_pkg::*;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    fun_fpusqr_sched_if io ();

    fun_fpusqr_sched #(.LAT_S(14), .LAT_D(28)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] mask, input logic [12:0] op,
                         input logic [8:0] regno, input logic [9:0] ii);
        io.u1_en    = mask;
        io.u1_op    = op;
        io.u1_regNo = regno;
        io.u1_II    = ii;
    endtask

    task automatic no_issue();
        io.u1_en    = '0;
        io.u1_op    = '0;
        io.u1_regNo = '0;
        io.u1_II    = '0;
    endtask

    initial begin
        rst        = 1'b1;
        io.except  = 1'b0;
        io.wb_busy = 1'b0;
        no_issue();
        step(); step(); step();
        chk("rst_sq_start", 32'(io.sq_start), 32'd0);
        chk("rst_pause", 32'(io.fxFRT_pause), 32'h0);
        chk("rst_fuwen", 32'(io.FUwen), 32'd0);
        chk("rst_alten", 32'(io.fxFRT_alten), 32'h0);
        rst = 1'b0;
        step();

        // 1: double sqrt, write-back at T+29
        issue(4'b0001, fop_sqrtDH, 9'd33, 10'd5);
        step();
        no_issue();
        chk("t1_start", 32'(io.sq_start), 32'd1);
        chk("t1_sq_op", 32'(io.sq_op), 32'(fop_sqrtDH));
        chk("t1_pause_hi", 32'(io.fxFRT_pause), 32'hF);
        step();
        chk("t1_start_once", 32'(io.sq_start), 32'd0);
        for (int c = 3; c <= 28; c++) begin
            step();
            chk("t1_no_early_wb", 32'(io.FUwen), 32'd0);
        end
        step();
        chk("t1_fuwen", 32'(io.FUwen), 32'd1);
        chk("t1_alten", 32'(io.fxFRT_alten), 32'h1);
        chk("t1_outen", 32'(io.outEn), 32'h1);
        chk("t1_outII", 32'(io.outII), 32'd5);
        chk("t1_FUreg", 32'(io.FUreg), 32'd33);
        chk("t1_outOp", 32'(io.outOp), 32'(fop_sqrtDH));
        chk("t1_pause_wb", 32'(io.fxFRT_pause), 32'hF);
        step();
        chk("t1_fuwen_off", 32'(io.FUwen), 32'd0);
        chk("t1_alten_off", 32'(io.fxFRT_alten), 32'h0);
        chk("t1_pause_lo", 32'(io.fxFRT_pause), 32'h0);

        // 2: single div, second op lands in pending and starts right after the first write-back
        issue(4'b0010, fop_divS, 9'd40, 10'd7);
        step();
        chk("t2_start1", 32'(io.sq_start), 32'd1);
        issue(4'b0100, fop_sqrtS, 9'd41, 10'd8);
        step();
        no_issue();
        chk("t2_no_start2", 32'(io.sq_start), 32'd0);
        chk("t2_pause", 32'(io.fxFRT_pause), 32'hF);
        for (int c = 3; c <= 14; c++) begin
            step();
            chk("t2_no_early_wb1", 32'(io.FUwen), 32'd0);
        end
        step();
        chk("t2_fuwen1", 32'(io.FUwen), 32'd1);
        chk("t2_outII1", 32'(io.outII), 32'd7);
        chk("t2_outOp1", 32'(io.outOp), 32'(fop_divS));
        chk("t2_alten1", 32'(io.fxFRT_alten), 32'h2);
        chk("t2_start_wait", 32'(io.sq_start), 32'd0);
        step();
        chk("t2_start2", 32'(io.sq_start), 32'd1);
        chk("t2_sq_op2", 32'(io.sq_op), 32'(fop_sqrtS));
        chk("t2_fuwen_gap", 32'(io.FUwen), 32'd0);
        chk("t2_pause2", 32'(io.fxFRT_pause), 32'hF);
        for (int c = 17; c <= 29; c++) begin
            step();
            chk("t2_no_early_wb2", 32'(io.FUwen), 32'd0);
        end
        step();
        chk("t2_fuwen2", 32'(io.FUwen), 32'd1);
        chk("t2_outII2", 32'(io.outII), 32'd8);
        chk("t2_FUreg2", 32'(io.FUreg), 32'd41);
        chk("t2_alten2", 32'(io.fxFRT_alten), 32'h4);
        step();
        chk("t2_pause_lo", 32'(io.fxFRT_pause), 32'h0);

        // 3: wb_busy for three cycles delays the write-back by three
        issue(4'b0001, fop_divS, 9'd3, 10'd12);
        step();
        no_issue();
        for (int c = 2; c <= 14; c++) step();
        io.wb_busy = 1'b1;
        step();
        chk("t3_hold_a_fuwen", 32'(io.FUwen), 32'd0);
        chk("t3_hold_a_alten", 32'(io.fxFRT_alten), 32'h0);
        chk("t3_hold_pause", 32'(io.fxFRT_pause), 32'hF);
        step();
        chk("t3_hold_b_fuwen", 32'(io.FUwen), 32'd0);
        chk("t3_hold_b_outII", 32'(io.outII), 32'd0);
        step();
        io.wb_busy = 1'b0;
        chk("t3_hold_c_fuwen", 32'(io.FUwen), 32'd0);
        step();
        chk("t3_fuwen", 32'(io.FUwen), 32'd1);
        chk("t3_outII", 32'(io.outII), 32'd12);
        step();
        chk("t3_pause_lo", 32'(io.fxFRT_pause), 32'h0);

        // 4: except at T+7 kills a running double op; a new op at T+8 runs normally
        issue(4'b1000, fop_sqrtDH, 9'd50, 10'd20);
        step();
        no_issue();
        chk("t4_start", 32'(io.sq_start), 32'd1);
        for (int c = 2; c <= 7; c++) step();
        io.except = 1'b1;
        step();
        io.except = 1'b0;
        chk("t4_pause_lo", 32'(io.fxFRT_pause), 32'h0);
        chk("t4_fuwen", 32'(io.FUwen), 32'd0);
        issue(4'b0001, fop_sqrtS, 9'd2, 10'd9);
        step();
        no_issue();
        chk("t4_restart", 32'(io.sq_start), 32'd1);
        chk("t4_restart_op", 32'(io.sq_op), 32'(fop_sqrtS));
        chk("t4_pause_hi", 32'(io.fxFRT_pause), 32'hF);
        for (int c = 10; c <= 22; c++) begin
            step();
            chk("t4_no_wb", 32'(io.FUwen), 32'd0);
        end
        step();
        chk("t4_fuwen_new", 32'(io.FUwen), 32'd1);
        chk("t4_outII_new", 32'(io.outII), 32'd9);
        for (int c = 24; c <= 32; c++) begin
            step();
            chk("t4_killed_no_wb", 32'(io.FUwen), 32'd0);
            chk("t4_pause_idle", 32'(io.fxFRT_pause), 32'h0);
        end

        // 5: reset during a stalled WB with a pending op abandons both
        issue(4'b0001, fop_divS, 9'd60, 10'd30);
        step();
        issue(4'b0010, fop_divS, 9'd61, 10'd31);
        step();
        no_issue();
        for (int c = 3; c <= 14; c++) step();
        io.wb_busy = 1'b1;
        step();
        chk("t5_wb_stalled", 32'(io.FUwen), 32'd0);
        chk("t5_pause_wb", 32'(io.fxFRT_pause), 32'hF);
        rst = 1'b1;
        step();
        rst        = 1'b0;
        io.wb_busy = 1'b0;
        chk("t5_sq_start", 32'(io.sq_start), 32'd0);
        chk("t5_pause", 32'(io.fxFRT_pause), 32'h0);
        chk("t5_fuwen", 32'(io.FUwen), 32'd0);
        chk("t5_alten", 32'(io.fxFRT_alten), 32'h0);
        chk("t5_outen", 32'(io.outEn), 32'h0);
        chk("t5_outII", 32'(io.outII), 32'd0);
        for (int c = 0; c < 20; c++) begin
            step();
            chk("t5_pend_dead", 32'(io.sq_start), 32'd0);
            chk("t5_no_wb", 32'(io.FUwen), 32'd0);
        end

        // 6: op offered with except in IDLE is ignored
        io.except = 1'b1;
        issue(4'b0001, fop_sqrtS, 9'd5, 10'd6);
        step();
        io.except = 1'b0;
        no_issue();
        chk("t6_no_start", 32'(io.sq_start), 32'd0);
        chk("t6_pause", 32'(io.fxFRT_pause), 32'h0);
        step();
        chk("t6_no_start_late", 32'(io.sq_start), 32'd0);
        chk("t6_pause_late", 32'(io.fxFRT_pause), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
